// File: rtl/alu_seq.sv
// alu_seq - sequential, parametrised ALU with valid/ready handshakes.
//
// One command (op, a, b) is accepted in IDLE when in_valid && in_ready.
// Most ops are computed combinationally and registered at the accept edge,
// so the result is valid one cycle later. MUL (shift-add) and DIV with a
// non-zero divisor (restoring) iterate once per cycle for WIDTH cycles.
// The result is held in DONE until the consumer takes it.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    command handshake
//   op[3:0], a, b         opcode and unsigned operands (WIDTH bits)
//   out_valid, out_ready  result handshake
//   res_lo, res_hi        low / high halves of the 2*WIDTH result
//   carry                 carry, borrow or shifted-out bit
//   zero                  the full {res_hi,res_lo} is zero
//   err                   divide by zero
//   busy                  state machine is not IDLE
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_ROR  = 4'h4;
    localparam logic [3:0] OP_ROL  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_XOR  = 4'hC;
    localparam logic [3:0] OP_NAND = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]        cnt_reg;
    logic                 is_div_reg;
    // MUL: {partial product high, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0]   x_reg;
    // MUL: multiplicand, DIV: divisor
    logic [WIDTH-1:0]     m_reg;

    logic [WIDTH-1:0]     res_lo_reg, res_hi_reg;
    logic                 carry_reg, zero_reg, err_reg;

    logic                 accept;
    logic                 iter_op;
    logic                 last_iter;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     sc_lo, sc_hi;
    logic                 sc_carry, sc_err;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra MSB of the difference is the borrow (a < b).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_lo    = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
            end
            OP_SUB: begin
                sc_lo    = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];
            end
            OP_DIV: begin
                // Only reached on this path when b == 0.
                sc_lo  = '1;
                sc_hi  = a;
                sc_err = 1'b1;
            end
            OP_ROR:  sc_lo = {a[0], a[WIDTH-1:1]};
            OP_ROL:  sc_lo = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_SHL: begin
                sc_lo    = {a[WIDTH-2:0], 1'b0};
                sc_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                sc_lo    = {1'b0, a[WIDTH-1:1]};
                sc_carry = a[0];
            end
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_NOT:  sc_lo = ~a;
            OP_NOR:  sc_lo = ~(a | b);
            OP_XOR:  sc_lo = a ^ b;
            OP_NAND: sc_lo = ~(a & b);
            OP_GT:   sc_lo = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   sc_lo = {{(WIDTH-1){1'b0}}, (a == b)};
            default: ;  // OP_MUL goes through the iterative path
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one step per BUSY cycle
    // ------------------------------------------------------------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem;
    logic [WIDTH:0]       div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole register right by one,
    // keeping the carry of the addition as the new MSB.
    assign mul_sum  = {1'b0, x_reg[2*WIDTH-1:WIDTH]}
                    + (x_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, x_reg[WIDTH-1:1]};

    // Restoring division: shift the next dividend bit into the remainder,
    // subtract the divisor when it fits and record a quotient 1.
    assign div_rem  = {x_reg[2*WIDTH-1:WIDTH], x_reg[WIDTH-1]};
    assign div_ge   = (div_rem >= {1'b0, m_reg});
    assign div_sub  = div_rem - {1'b0, m_reg};
    assign div_next = {(div_ge ? div_sub[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                       x_reg[WIDTH-2:0], div_ge};

    assign step_next = is_div_reg ? div_next : mul_next;

    assign iter_op   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = iter_op ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            x_reg      <= '0;
            m_reg      <= '0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            cnt_reg <= '0;
            if (iter_op) begin
                is_div_reg <= (op == OP_DIV);
                x_reg      <= {{WIDTH{1'b0}}, (op == OP_DIV) ? a : b};
                m_reg      <= (op == OP_DIV) ? b : a;
            end else begin
                res_lo_reg <= sc_lo;
                res_hi_reg <= sc_hi;
                carry_reg  <= sc_carry;
                err_reg    <= sc_err;
                zero_reg   <= ({sc_hi, sc_lo} == '0);
            end
        end else if (state_reg == BUSY) begin
            x_reg   <= step_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter) begin
                res_lo_reg <= step_next[WIDTH-1:0];
                res_hi_reg <= step_next[2*WIDTH-1:WIDTH];
                carry_reg  <= 1'b0;
                err_reg    <= 1'b0;
                zero_reg   <= (step_next == '0);
            end
        end
    end

    assign res_lo = res_lo_reg;
    assign res_hi = res_hi_reg;
    assign carry  = carry_reg;
    assign zero   = zero_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq - directed self-checking bench for alu_seq (WIDTH=8).
// Inputs are driven 1 time unit after each rising edge; outputs are
// sampled at the same point, away from the active edge.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res_lo;
    logic [7:0] res_hi;
    logic       carry;
    logic       zero;
    logic       err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for the result, check it, then consume it.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [7:0] xa, input logic [7:0] xb,
                          input int lat, input logic [15:0] exp_res,
                          input logic ec, input logic ez, input logic ee);
        int n;
        in_valid = 1'b1;
        op = o;
        a  = xa;
        b  = xb;
        tick();
        // Scramble inputs after the accept edge; they must be ignored.
        in_valid = 1'b0;
        op = 4'h9;
        a  = 8'hAA;
        b  = 8'h55;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        $display("txn %s op=%h a=%h b=%h -> res=%h%h c=%b z=%b e=%b after %0d cycles",
                 tag, o, xa, xb, res_hi, res_lo, carry, zero, err, n);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_res"}, {res_hi, res_lo}, exp_res);
        chk({tag, "_carry"}, carry, ec);
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_err"}, err, ee);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, {out_valid, busy, in_ready}, 3'b001);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        a         = 8'h00;
        b         = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res", {res_hi, res_lo}, 16'h0000);
        chk("rst_flags", {carry, zero, err}, 3'b000);

        // Single-cycle ops
        run_op("add",  4'h0, 8'hF0, 8'h20, 1, 16'h0010, 1'b1, 1'b0, 1'b0);
        run_op("sub",  4'h1, 8'h03, 8'h05, 1, 16'h00FE, 1'b1, 1'b0, 1'b0);
        run_op("eq",   4'hF, 8'h5A, 8'h5A, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("xor",  4'hC, 8'h5A, 8'h5A, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("gt",   4'hE, 8'h05, 8'h03, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("not",  4'hA, 8'h0F, 8'h00, 1, 16'h00F0, 1'b0, 1'b0, 1'b0);
        run_op("shl",  4'h6, 8'h81, 8'h00, 1, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op("ror",  4'h4, 8'h01, 8'h00, 1, 16'h0080, 1'b0, 1'b0, 1'b0);
        run_op("nand", 4'hD, 8'hF0, 8'h3C, 1, 16'h00CF, 1'b0, 1'b0, 1'b0);

        // MUL 0xFF*0xFF with in_valid held high while busy
        in_valid = 1'b1;
        op = 4'h2;
        a  = 8'hFF;
        b  = 8'hFF;
        tick();
        op = 4'h0;
        a  = 8'h01;
        b  = 8'h01;
        n = 1;
        while (!out_valid && n < 40) begin
            chk("mul_busy", busy, 1);
            chk("mul_in_ready", in_ready, 0);
            tick();
            n++;
        end
        in_valid = 1'b0;
        $display("txn mul op=2 a=ff b=ff -> res=%h%h after %0d cycles", res_hi, res_lo, n);
        chk("mul_latency", n, 9);
        chk("mul_res", {res_hi, res_lo}, 16'hFE01);
        chk("mul_flags", {carry, zero, err}, 3'b000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mul_no_extra_accept", {out_valid, busy, in_ready}, 3'b001);

        // Divide
        run_op("div",   4'h3, 8'd200, 8'd7, 9, {8'd4, 8'd28}, 1'b0, 1'b0, 1'b0);
        run_op("div0",  4'h3, 8'h33, 8'h00, 1, 16'h33FF, 1'b0, 1'b0, 1'b1);
        run_op("mul2",  4'h2, 8'h12, 8'h34, 9, 16'h03A8, 1'b0, 1'b0, 1'b0);

        // Backpressure on ROL 0x81
        in_valid = 1'b1;
        op = 4'h5;
        a  = 8'h81;
        b  = 8'h00;
        tick();
        in_valid = 1'b0;
        a = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_res_lo", res_lo, 8'h03);
            tick();
        end
        $display("txn rol op=5 a=81 -> res=%h%h held under backpressure", res_hi, res_lo);
        chk("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", {out_valid, busy, in_ready}, 3'b001);
        run_op("and_after_bp", 4'h8, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a MUL
        in_valid = 1'b1;
        op = 4'h2;
        a  = 8'h12;
        b  = 8'h34;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_mul_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("txn reset during mul -> busy=%b out_valid=%b in_ready=%b", busy, out_valid, in_ready);
        chk("mrst_state", {out_valid, busy, in_ready}, 3'b001);
        chk("mrst_res", {res_hi, res_lo}, 16'h0000);
        chk("mrst_flags", {carry, zero, err}, 3'b000);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) n++;
            tick();
        end
        chk("mrst_no_result", n, 0);
        run_op("shr", 4'h7, 8'h01, 8'h00, 1, 16'h0000, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the team's 4-bit combinational ALU.
- Operand width is set by a parameter, and every result is registered.
- Operands and results move through a valid/ready handshake on both sides.
- MUL and DIV are iterative (shift-add / restoring), so a multi-cycle unit can sit behind a FIFO or a command sequencer.

Parameters:
- WIDTH, 8, operand width in bits (legal values are 2 and above); the result is 2*WIDTH bits, split into res_hi and res_lo.

Ports:
- clk  input  1  clock; all logic changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  a command is present on op/a/b.
- in_ready  output  1  the block can accept a command.
- op  input  4  opcode.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  the consumer accepts the result.
- res_lo  output  WIDTH  result bits [WIDTH-1:0].
- res_hi  output  WIDTH  result bits [2*WIDTH-1:WIDTH].
- carry  output  1  carry, borrow or shifted-out bit.
- zero  output  1  the full 2*WIDTH result is zero.
- err  output  1  divide by zero.
- busy  output  1  the state machine is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; the iteration counter and internal registers clear.
  - out_valid, res_lo, res_hi, carry, zero, err and busy all become 0.
  - in_ready becomes 1.
  - Reset wins over every other event, including a mid-BUSY MUL/DIV (aborted, no result produced) and a pending DONE result (discarded).
- State machine: IDLE -> (BUSY) -> DONE -> IDLE.
  - IDLE: in_ready=1. A command is accepted when in_valid && in_ready; op, a and b are latched at that edge and later input changes are ignored.
  - Single-cycle ops: the result is computed and registered at the accept edge, then the state goes to DONE. out_valid=1 in the following cycle (latency 1).
  - MUL/DIV with b!=0: state goes to BUSY. The block performs exactly WIDTH iterations, one per cycle, then enters DONE. out_valid is first high WIDTH+1 cycles after the accept edge.
  - BUSY: in_ready=0 and out_valid=0.
  - DONE: out_valid=1 and in_ready=0. Outputs hold stable until out_valid && out_ready at an edge, then the state returns to IDLE and out_valid drops next cycle. There is no overlap: a new command can be accepted at the earliest one cycle after the output handshake.
  - Output registers keep their last value in IDLE/BUSY; only out_valid qualifies them.
- Opcodes (results are zero-extended to 2*WIDTH unless stated; carry=0 unless stated):
  - 0 ADD: a+b; carry = bit WIDTH of the sum; res_hi=0.
  - 1 SUB: a-b mod 2^WIDTH; carry = borrow (a<b).
  - 2 MUL: full 2*WIDTH product; iterative shift-add.
  - 3 DIV: res_lo = quotient, res_hi = remainder; iterative restoring.
  - 4 ROR: rotate a right by 1.
  - 5 ROL: rotate a left by 1.
  - 6 SHL: a<<1 truncated to WIDTH; carry = a[WIDTH-1].
  - 7 SHR: a>>1; carry = a[0].
  - 8 AND, 9 OR, A NOT a, B NOR, C XOR, D NAND: WIDTH-bit bitwise results.
  - E GT: result 1 if a>b, else 0.
  - F EQ: result 1 if a==b, else 0.
- Divide by zero (op=3, b=0): handled as a single-cycle op with no BUSY. res_lo = all ones, res_hi = a, err=1. err=0 for every other result.
- zero is computed on the full {res_hi,res_lo} and registered together with the result.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, reset, then ADD a=0xF0 b=0x20 -> 1 cycle after accept: out_valid=1, res_lo=0x10, res_hi=0x00, carry=1, zero=0.
- SUB a=0x03 b=0x05 -> res_lo=0xFE, carry=1. Then EQ a=0x5A b=0x5A -> res_lo=0x01. Then XOR a=0x5A b=0x5A -> res_lo=0x00, zero=1.
- MUL a=0xFF b=0xFF -> busy for 8 iterations, out_valid 9 cycles after accept, {res_hi,res_lo}=0xFE01. in_valid held high during BUSY must not be accepted (in_ready=0).
- DIV a=200 b=7 -> res_lo=28, res_hi=4, err=0. DIV a=0x33 b=0 -> out_valid after 1 cycle, res_lo=0xFF, res_hi=0x33, err=1.
- Backpressure: ROL a=0x81 with out_ready=0 for 5 cycles -> out_valid and res_lo=0x03 held stable. On out_ready=1: one handshake, IDLE next cycle, a new command accepted the cycle after.
- Reset mid-MUL (rst at iteration 4) -> next cycle state is IDLE, all outputs 0, in_ready=1, and no result ever appears. A subsequent SHR a=0x01 gives res_lo=0x00, carry=1, zero=1.
